// File: rtl/qpu_ir_issue_fifo_pkg.sv
// Shared widths and field positions for the QPU instruction-register issue FIFO.
// The values mirror the QPU_INSTR_SIZE, QPU_PC_SIZE and QPU_RFIDX_REAL_WIDTH defines.
package qpu_ir_issue_fifo_pkg;
  localparam int QPU_INSTR_SIZE       = 32;
  localparam int QPU_PC_SIZE          = 32;
  localparam int QPU_RFIDX_REAL_WIDTH = 5;
  localparam int QPU_RS1_LSB          = 15;
  localparam int QPU_RS2_LSB          = 20;
  localparam int QPU_IR_FIFO_DEPTH    = 4;
endpackage

// File: rtl/qpu_ir_predec.sv
// Combinational extraction of the rs1/rs2 register indices from an instruction word.
// It can stand in for the minidec rs-index path.
module qpu_ir_predec
  import qpu_ir_issue_fifo_pkg::*;
#(
  parameter int INSTR_W = QPU_INSTR_SIZE,
  parameter int RFIDX_W = QPU_RFIDX_REAL_WIDTH,
  parameter int RS1_LSB = QPU_RS1_LSB,
  parameter int RS2_LSB = QPU_RS2_LSB
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [RFIDX_W-1:0] rs1idx,
  output logic [RFIDX_W-1:0] rs2idx
);
  // Only the two index fields matter here; the rest of the word is deliberately ignored.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr;

  assign rs1idx = instr[RS1_LSB +: RFIDX_W];
  assign rs2idx = instr[RS2_LSB +: RFIDX_W];
endmodule

// File: rtl/qpu_ir_issue_fifo.sv
// Instruction-register stage between IFU and EXU: a DEPTH-entry FIFO of {instr, pc, prdt_taken}
// with valid/ready on both sides, pipeline flush, and rs1/rs2 predecode of the head entry.
module qpu_ir_issue_fifo
  import qpu_ir_issue_fifo_pkg::*;
#(
  parameter int INSTR_W = QPU_INSTR_SIZE,
  parameter int PC_W    = QPU_PC_SIZE,
  parameter int RFIDX_W = QPU_RFIDX_REAL_WIDTH,
  parameter int RS1_LSB = QPU_RS1_LSB,
  parameter int RS2_LSB = QPU_RS2_LSB,
  parameter int DEPTH   = QPU_IR_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [INSTR_W-1:0]       i_ir,
  input  logic [PC_W-1:0]          i_pc,
  input  logic                     i_prdt_taken,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [INSTR_W-1:0]       o_ir,
  output logic [PC_W-1:0]          o_pc,
  output logic                     o_prdt_taken,
  output logic [RFIDX_W-1:0]       o_rs1idx,
  output logic [RFIDX_W-1:0]       o_rs2idx,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [INSTR_W-1:0]  ir_mem [DEPTH];
  logic [PC_W-1:0]     pc_mem [DEPTH];
  logic [DEPTH-1:0]    tk_mem;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty  = (wr_ptr == rd_ptr);
  assign push   = i_valid && !full;
  assign pop    = o_ready && !empty;

  // Flush outranks both push and pop: the pointers collapse to zero and any coincident transfer is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; a slot is only observable once the write pointer has passed it.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      ir_mem[wr_idx] <= i_ir;
      pc_mem[wr_idx] <= i_pc;
      tk_mem[wr_idx] <= i_prdt_taken;
    end
  end

  assign i_ready      = !full;
  assign o_valid      = !empty;
  assign o_count      = wr_ptr - rd_ptr;
  assign o_ir         = empty ? '0   : ir_mem[rd_idx];
  assign o_pc         = empty ? '0   : pc_mem[rd_idx];
  assign o_prdt_taken = empty ? 1'b0 : tk_mem[rd_idx];

  qpu_ir_predec #(
    .INSTR_W (INSTR_W),
    .RFIDX_W (RFIDX_W),
    .RS1_LSB (RS1_LSB),
    .RS2_LSB (RS2_LSB)
  ) u_predec (
    .instr  (o_ir),
    .rs1idx (o_rs1idx),
    .rs2idx (o_rs2idx)
  );
endmodule

// File: tb/tb_qpu_ir_issue_fifo.sv
// Bench for qpu_ir_issue_fifo: a queue model of the FIFO checked every cycle,
// plus directed scenarios with literal expectations.
module tb_qpu_ir_issue_fifo;
  localparam int DEPTH   = 4;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int RFIDX_W = 5;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid;
  logic               i_ready;
  logic [INSTR_W-1:0] i_ir;
  logic [PC_W-1:0]    i_pc;
  logic               i_prdt_taken;
  logic               o_valid;
  logic               o_ready;
  logic [INSTR_W-1:0] o_ir;
  logic [PC_W-1:0]    o_pc;
  logic               o_prdt_taken;
  logic [RFIDX_W-1:0] o_rs1idx;
  logic [RFIDX_W-1:0] o_rs2idx;
  logic               flush;
  logic [CW-1:0]      o_count;

  qpu_ir_issue_fifo #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .RFIDX_W (RFIDX_W),
    .RS1_LSB (15),
    .RS2_LSB (20),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .i_ir         (i_ir),
    .i_pc         (i_pc),
    .i_prdt_taken (i_prdt_taken),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_ir         (o_ir),
    .o_pc         (o_pc),
    .o_prdt_taken (o_prdt_taken),
    .o_rs1idx     (o_rs1idx),
    .o_rs2idx     (o_rs2idx),
    .flush        (flush),
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    pc;
    logic               tk;
  } ent_t;

  ent_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  bit   started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: an ordered queue of at most DEPTH entries.
  always @(posedge clk or posedge rst) begin
    bit do_push;
    bit do_pop;
    if (rst) begin
      q.delete();
    end else begin
      do_push = i_valid && (q.size() < DEPTH);
      do_pop  = o_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back('{ir: i_ir, pc: i_pc, tk: i_prdt_taken});
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("o_valid", 64'(o_valid), 64'(q.size() != 0));
      check("i_ready", 64'(i_ready), 64'(q.size() < DEPTH));
      check("o_count", 64'(o_count), 64'(q.size()));
      if (q.size() != 0) begin
        check("o_ir",         64'(o_ir),         64'(q[0].ir));
        check("o_pc",         64'(o_pc),         64'(q[0].pc));
        check("o_prdt_taken", 64'(o_prdt_taken), 64'(q[0].tk));
        check("o_rs1idx",     64'(o_rs1idx),     64'(q[0].ir[19:15]));
        check("o_rs2idx",     64'(o_rs2idx),     64'(q[0].ir[24:20]));
      end else begin
        check("o_ir_empty", 64'(o_ir), 64'd0);
        check("o_pc_empty", 64'(o_pc), 64'd0);
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                      input logic tk, input logic rdy, input logic fl);
    i_valid      = v;
    i_ir         = ir;
    i_pc         = pc;
    i_prdt_taken = tk;
    o_ready      = rdy;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0; i_ir = '0; i_pc = '0; i_prdt_taken = 1'b0; o_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    check("reset_o_valid", 64'(o_valid), 64'd0);
    check("reset_i_ready", 64'(i_ready), 64'd1);
    check("reset_o_count", 64'(o_count), 64'd0);

    // Single push, head held
    step(1'b1, 32'h0000_8093, 32'h100, 1'b0, 1'b0, 1'b0);
    check("t1_o_valid", 64'(o_valid), 64'd1);
    check("t1_rs1idx",  64'(o_rs1idx), 64'd1);
    check("t1_count",   64'(o_count), 64'd1);
    check("t1_pc",      64'(o_pc), 64'h100);
    drain(1);

    // Fill to full, refused fifth push, pop while full
    for (int k = 0; k < 4; k++)
      step(1'b1, 32'h1000_0033 + 32'(k), 32'h300 + 32'(4 * k), 1'(k), 1'b0, 1'b0);
    check("t2_full_i_ready", 64'(i_ready), 64'd0);
    check("t2_full_count",   64'(o_count), 64'd4);
    step(1'b1, 32'hDEAD_0033, 32'h3F0, 1'b1, 1'b0, 1'b0);
    check("t2_fifth_count", 64'(o_count), 64'd4);
    step(1'b1, 32'hDEAD_0033, 32'h3F0, 1'b1, 1'b1, 1'b0);
    check("t2_pop_i_ready", 64'(i_ready), 64'd1);
    check("t2_pop_count",   64'(o_count), 64'd3);
    check("t2_head_pc",     64'(o_pc), 64'h304);
    drain(3);
    check("t2_drained", 64'(o_valid), 64'd0);

    // Streaming: one entry per cycle, pointers wrap several times
    for (int k = 0; k < 20; k++)
      step(1'b1, (32'(k) << 15) | (32'(k + 1) << 20) | 32'h33, 32'h1000 + 32'(4 * k), 1'(k), 1'b1, 1'b0);
    check("t3_count",  64'(o_count), 64'd1);
    check("t3_last_pc", 64'(o_pc), 64'h104C);
    check("t3_rs2idx", 64'(o_rs2idx), 64'd20);
    drain(1);

    // Flush with coincident push and pop
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h2000_0033 + 32'(k), 32'h400 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    check("t4_pre_flush_i_ready", 64'(i_ready), 64'd1);
    step(1'b1, 32'hBAD0_0033, 32'hBAD, 1'b1, 1'b1, 1'b1);
    check("t4_flush_o_valid", 64'(o_valid), 64'd0);
    check("t4_flush_count",   64'(o_count), 64'd0);
    step(1'b1, 32'h0050_0093, 32'h500, 1'b0, 1'b0, 1'b0);
    check("t4_after_flush_pc", 64'(o_pc), 64'h500);
    drain(1);

    // Asynchronous reset mid-stream
    step(1'b1, 32'h3000_0033, 32'h600, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3000_0133, 32'h604, 1'b1, 1'b0, 1'b0);
    i_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_o_valid", 64'(o_valid), 64'd0);
    check("t5_async_count",   64'(o_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 32'h0000_0113, 32'h200, 1'b0, 1'b0, 1'b0);
    check("t5_first_pc", 64'(o_pc), 64'h200);
    check("t5_count",    64'(o_count), 64'd1);

    // Stall while the producer toggles
    step(1'b1, 32'h0000_0213, 32'h204, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      step(1'(~k[0]), 32'h4000_0033 + 32'(k), 32'h700 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    check("t6_stall_pc",    64'(o_pc), 64'h200);
    check("t6_stall_count", 64'(o_count), 64'd4);
    drain(5);
    check("t6_drained", 64'(o_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
